// File: rtl/image_pkg.sv
// Shared encodings for the line-buffered image transform engine.
package image_pkg;

  // Per-frame transform selection; raw codes 6 and 7 decode to copy.
  typedef enum logic [2:0] {
    MODE_COPY    = 3'd0,
    MODE_XSHIFT  = 3'd1,
    MODE_YSHIFT  = 3'd2,
    MODE_SCALE   = 3'd3,
    MODE_HMIRROR = 3'd4,
    MODE_VFLIP   = 3'd5
  } mode_e;

  // Engine sequencing: one source line is read, then one destination line is written.
  typedef enum logic [2:0] {
    StIdle,
    StLineSetup,
    StRdReq,
    StRdDone,
    StWrPrime,
    StWrPresent,
    StWrReq,
    StWrDone
  } state_e;

  localparam logic [63:0] FILL_WORD_DEFAULT = 64'h0;

  function automatic mode_e decode_mode(input logic [2:0] raw);
    if (raw > 3'd5) begin
      return MODE_COPY;
    end
    return mode_e'(raw);
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line buffer: one write port, one synchronous read port (1-cycle latency).
module line_buffer_ram #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 64,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage write and registered read; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/image_line_engine.sv
// Line-buffered image transform engine: reads a source line in bursts into a line buffer, then
// writes the transformed destination line, ping-ponging frame banks every frame.
module image_line_engine
  import image_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned IMG_W         = 1024,
  parameter int unsigned IMG_H         = 768,
  parameter int unsigned BURST_LEN     = 16,
  parameter logic [ADDR_BITS-1:0] SRC_BASE0 = ADDR_BITS'(2073600),
  parameter logic [ADDR_BITS-1:0] SRC_BASE1 = ADDR_BITS'(0),
  parameter logic [ADDR_BITS-1:0] DST_BASE0 = ADDR_BITS'(6220800),
  parameter logic [ADDR_BITS-1:0] DST_BASE1 = ADDR_BITS'(4147200),
  parameter logic [MEM_DATA_BITS-1:0] FILL_WORD = MEM_DATA_BITS'(FILL_WORD_DEFAULT)
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [2:0]               mode,
  input  logic [10:0]              shift_x,
  input  logic [10:0]              shift_y,
  input  logic [3:0]               scale,
  output logic                     rd_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     image_addr_flag,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     error
);

  localparam int unsigned AW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned XW  = $clog2(IMG_W + 1);
  localparam int unsigned YW  = $clog2(IMG_H + 1);
  localparam int unsigned NCH = IMG_W / BURST_LEN;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LastChunk = CW'(NCH - 1);
  localparam logic [9:0]    BurstLen  = 10'(BURST_LEN);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [10:0]     shift_x_q, shift_x_d;
  logic [10:0]     shift_y_q, shift_y_d;
  logic [3:0]      scale_q, scale_d;
  logic [YW-1:0]   y_q, y_d;
  logic [YW-1:0]   sy_q, sy_d;
  logic            fill_line_q, fill_line_d;
  logic [CW-1:0]   chunk_q, chunk_d;
  logic [XW-1:0]   pix_q, pix_d;
  logic [9:0]      beat_q, beat_d;
  logic            fill_q, fill_d;
  logic            flag_q, flag_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q, busy_d;
  logic            error_q, error_d;

  logic [31:0]     y32, sy32, x32, sx32;
  logic            line_fill, pix_fill;
  logic [9:0]      rd_count;
  logic [XW-1:0]   next_chunk_pix;

  logic                     buf_we;
  logic [AW-1:0]            buf_waddr, buf_raddr;
  logic [MEM_DATA_BITS-1:0] buf_rdata;

  logic [ADDR_BITS-1:0] src_base, dst_base, rd_addr, wr_addr;

  line_buffer_ram #(
    .Depth (IMG_W),
    .Width (MEM_DATA_BITS),
    .AddrW (AW)
  ) u_line_buf (
    .clk_i   (mem_clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (rd_burst_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  // Source line for the current output line, or a whole-line fill when out of range.
  always_comb begin
    y32       = 32'(y_q);
    sy32      = y32;
    line_fill = 1'b0;
    case (mode_q)
      MODE_YSHIFT: begin
        if (y32 < 32'(shift_y_q)) line_fill = 1'b1;
        else                      sy32 = y32 - 32'(shift_y_q);
      end
      MODE_SCALE:  sy32 = y32 * 32'(scale_q);
      MODE_VFLIP:  sy32 = 32'(IMG_H - 1) - y32;
      default: ;
    endcase
    if (sy32 >= 32'(IMG_H)) line_fill = 1'b1;
  end

  // Buffer read index for the pixel that will be on wr_burst_data next cycle (1-cycle RAM).
  always_comb begin
    x32      = 32'(pix_d);
    sx32     = x32;
    pix_fill = fill_line_q;
    case (mode_q)
      MODE_XSHIFT: begin
        if (x32 < 32'(shift_x_q)) pix_fill = 1'b1;
        else                      sx32 = x32 - 32'(shift_x_q);
      end
      MODE_SCALE:   sx32 = x32 * 32'(scale_q);
      MODE_HMIRROR: sx32 = 32'(IMG_W - 1) - x32;
      default: ;
    endcase
    // Also catches pix_d == IMG_W after the last consume and mirror underflow.
    if (sx32 >= 32'(IMG_W)) pix_fill = 1'b1;
    buf_raddr = pix_fill ? '0 : AW'(sx32);
    fill_d    = pix_fill;
  end

  // Frame/line sequencing and burst bookkeeping.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    shift_x_d      = shift_x_q;
    shift_y_d      = shift_y_q;
    scale_d        = scale_q;
    y_d            = y_q;
    sy_d           = sy_q;
    fill_line_d    = fill_line_q;
    chunk_d        = chunk_q;
    pix_d          = pix_q;
    beat_d         = beat_q;
    flag_d         = flag_q;
    frame_done_d   = 1'b0;
    busy_d         = busy_q;
    error_d        = error_q;
    buf_we         = 1'b0;
    buf_waddr      = AW'(pix_q);
    rd_count       = beat_q + {9'd0, rd_burst_data_valid};
    next_chunk_pix = XW'((32'(chunk_q) + 32'd1) * 32'(BURST_LEN));

    case (state_q)
      StIdle: begin
        if (enable) begin
          mode_d    = decode_mode(mode);
          shift_x_d = shift_x;
          shift_y_d = shift_y;
          if (scale == 4'd0) begin
            scale_d = 4'd1;
            error_d = 1'b1;
          end else begin
            scale_d = scale;
          end
          busy_d  = 1'b1;
          state_d = StLineSetup;
        end
      end
      StLineSetup: begin
        sy_d        = line_fill ? '0 : YW'(sy32);
        fill_line_d = line_fill;
        chunk_d     = '0;
        pix_d       = '0;
        beat_d      = '0;
        state_d     = line_fill ? StWrPrime : StRdReq;
      end
      StRdReq: begin
        if (rd_burst_data_valid) begin
          // Excess beats are counted for the error check but never overrun the next chunk.
          if (beat_q < BurstLen) begin
            buf_we = 1'b1;
            pix_d  = pix_q + 1'b1;
          end
          if (beat_q != '1) beat_d = beat_q + 10'd1;
        end
        if (rd_burst_finish) begin
          if (rd_count != BurstLen) error_d = 1'b1;
          state_d = StRdDone;
        end
      end
      StRdDone: begin
        beat_d = '0;
        if (chunk_q == LastChunk) begin
          chunk_d = '0;
          pix_d   = '0;
          state_d = StWrPrime;
        end else begin
          chunk_d = chunk_q + 1'b1;
          pix_d   = next_chunk_pix;
          state_d = StRdReq;
        end
      end
      StWrPrime:   state_d = StWrPresent;
      StWrPresent: state_d = StWrReq;
      StWrReq: begin
        if (wr_burst_data_req && (beat_q < BurstLen)) begin
          pix_d  = pix_q + 1'b1;
          beat_d = beat_q + 10'd1;
        end
        if (wr_burst_finish) state_d = StWrDone;
      end
      StWrDone: begin
        beat_d = '0;
        if (chunk_q != LastChunk) begin
          chunk_d = chunk_q + 1'b1;
          pix_d   = next_chunk_pix;
          state_d = StWrPrime;
        end else if (y_q == YW'(IMG_H - 1)) begin
          y_d          = '0;
          frame_done_d = 1'b1;
          flag_d       = ~flag_q;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end else begin
          y_d     = y_q + 1'b1;
          state_d = StLineSetup;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= MODE_COPY;
      shift_x_q    <= '0;
      shift_y_q    <= '0;
      scale_q      <= 4'd1;
      y_q          <= '0;
      sy_q         <= '0;
      fill_line_q  <= 1'b0;
      chunk_q      <= '0;
      pix_q        <= '0;
      beat_q       <= '0;
      fill_q       <= 1'b0;
      flag_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      shift_x_q    <= shift_x_d;
      shift_y_q    <= shift_y_d;
      scale_q      <= scale_d;
      y_q          <= y_d;
      sy_q         <= sy_d;
      fill_line_q  <= fill_line_d;
      chunk_q      <= chunk_d;
      pix_q        <= pix_d;
      beat_q       <= beat_d;
      fill_q       <= fill_d;
      flag_q       <= flag_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  // Burst addresses in full ADDR_BITS width; products are widened before the add.
  always_comb begin
    src_base = flag_q ? SRC_BASE1 : SRC_BASE0;
    dst_base = flag_q ? DST_BASE1 : DST_BASE0;
    rd_addr  = src_base + ADDR_BITS'(sy_q) * ADDR_BITS'(IMG_W)
             + ADDR_BITS'(chunk_q) * ADDR_BITS'(BURST_LEN);
    wr_addr  = dst_base + ADDR_BITS'(y_q) * ADDR_BITS'(IMG_W)
             + ADDR_BITS'(chunk_q) * ADDR_BITS'(BURST_LEN);
  end

  // Output drive; addresses and data are zero outside their phases so reset shows all-zero.
  always_comb begin
    rd_burst_req    = (state_q == StRdReq);
    wr_burst_req    = (state_q == StWrReq);
    rd_burst_len    = BurstLen;
    wr_burst_len    = BurstLen;
    rd_burst_addr   = rd_burst_req ? rd_addr : '0;
    wr_burst_addr   = wr_burst_req ? wr_addr : '0;
    wr_burst_data   = '0;
    if ((state_q == StWrPresent) || (state_q == StWrReq)) begin
      wr_burst_data = fill_q ? FILL_WORD : buf_rdata;
    end
    image_addr_flag = flag_q;
    frame_done      = frame_done_q;
    busy            = busy_q;
    error           = error_q;
  end

endmodule
